// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer family: the FSM state type,
// the production qualification length and a short length for simulation.
package debounce_pkg;

    // Debouncer FSM states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } db_state_t;

    // 10 ms at 100 MHz.
    localparam int unsigned STABLE_CYCLES_DEFAULT = 1_000_000;

    // Short qualification length that keeps simulations fast.
    localparam int unsigned STABLE_CYCLES_SIM = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for asynchronous pin inputs. Both stages clear to 0
// on the synchronous active-high reset. Reusable by any pin-input block.
module sync_2ff (
    input  logic clk,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the raw pin through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button/switch pin: synchronises it into clk, requires
// STABLE_CYCLES consecutive equal synchronised samples before the output
// level follows, and optionally emits one-cycle rise/fall strobes.
// Optional feature macro: BUTTON_DEBOUNCER_EDGE_EN (strobes built when
// defined; tied to 0 otherwise).
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic RST,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    sync_2ff u_sync (
        .clk (clk),
        .RST (RST),
        .d   (btn_in),
        .q   (s)
    );

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;
`endif

    // Next-state logic: the counter holds the number of consecutive samples
    // of s that disagree with the current level; the entering sample counts
    // as 1, so the completing edge is the STABLE_CYCLES-th such sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`endif
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
                    rise_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
    end

    // State, counter and level registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    // Strobe registers: high for the single cycle after a completed change.
    always_ff @(posedge clk) begin
        if (RST) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign btn_rise = rise_q;
    assign btn_fall = fall_q;
`else
    assign btn_rise = 1'b0;
    assign btn_fall = 1'b0;
`endif

    assign btn_level = level_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with STABLE_CYCLES=4 and a 20 ns
// clock. A behavioural model (pin delayed two samples, then a run-length
// count of samples disagreeing with the level) is compared every cycle;
// directed sequences pin the model and DUT with literal expectations.
module tb_button_debouncer;
    import debounce_pkg::*;

    localparam int unsigned S = STABLE_CYCLES_SIM;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    localparam bit EDGES = 1'b1;
`else
    localparam bit EDGES = 1'b0;
`endif

    logic clk    = 1'b0;
    logic RST    = 1'b1;
    logic btn_in = 1'b1;
    logic btn_level, btn_rise, btn_fall;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .RST       (RST),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the debounced level follows the pin once the pin
    // value seen two edges earlier has disagreed with it S times in a row.
    bit m_hist [2];
    bit m_level, m_rise, m_fall;
    int m_run;

    initial begin
        m_hist[0] = 1'b0; m_hist[1] = 1'b0;
        m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end

    always @(posedge clk) begin
        bit s;
        if (RST) begin
            m_hist[0] = 1'b0; m_hist[1] = 1'b0;
            m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        end else begin
            s         = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = btn_in;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            if (s == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == int'(S)) begin
                    m_level = s;
                    m_rise  = EDGES & s;
                    m_fall  = EDGES & !s;
                    m_run   = 0;
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("level", btn_level, m_level);
            check("rise", btn_rise, m_rise);
            check("fall", btn_fall, m_fall);
            check("rise_fall_exclusive", btn_rise & btn_fall, 1'b0);
        end
    end

    task automatic hold(input logic v, input int unsigned n);
        @(negedge clk);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset for 2 cycles with the pin high.
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_level", btn_level, 1'b0);
        check("reset_rise", btn_rise, 1'b0);
        check("reset_fall", btn_fall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        RST = 1'b0;

        // Pin held high through release: k is the first post-reset edge.
        @(posedge clk);                 // k
        repeat (4) @(posedge clk);      // k+4
        #1 check("press_k4_level", btn_level, 1'b0);
        @(posedge clk);                 // k+5
        #1 check("press_k5_level", btn_level, 1'b1);
        check("press_k5_rise", btn_rise, EDGES);
        check("model_press_level", m_level, 1'b1);
        @(posedge clk);                 // k+6
        #1 check("press_k6_rise", btn_rise, 1'b0);
        check("press_k6_level", btn_level, 1'b1);

        // Clean release.
        @(negedge clk);
        btn_in = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 check("release_k4_level", btn_level, 1'b1);
        @(posedge clk);
        #1 check("release_k5_level", btn_level, 1'b0);
        check("release_k5_fall", btn_fall, EDGES);
        check("model_release_level", m_level, 1'b0);
        @(posedge clk);
        #1 check("release_k6_fall", btn_fall, 1'b0);

        // Bounce: 3 high, 2 low, 3 high, then low.
        hold(1'b1, 3);
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        btn_in = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_level", btn_level, 1'b0);
        check("model_bounce_level", m_level, 1'b0);

        // Reset mid-qualification.
        @(negedge clk);
        btn_in = 1'b1;
        @(posedge clk);                 // k
        @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk);                 // k+2 (FSM would enter WAIT_HIGH)
        @(posedge clk);                 // k+3
        #1 check("midrst_level", btn_level, 1'b0);
        check("midrst_rise", btn_rise, 1'b0);
        @(negedge clk);
        RST = 1'b0;
        @(posedge clk);                 // first post-reset sampling edge
        repeat (4) @(posedge clk);
        #1 check("midrst_k4_level", btn_level, 1'b0);
        @(posedge clk);
        #1 check("midrst_k5_level", btn_level, 1'b1);
        check("midrst_k5_rise", btn_rise, EDGES);
        hold(1'b0, 10);

        // Jitter: five toggles at random 1-7 ns spacing, then settle.
        for (int r = 0; r < 20; r++) begin
            @(posedge clk);
            #1;
            for (int t = 0; t < 5; t++) begin
                int unsigned d;
                d = $urandom_range(1, 7);
                if ((($time + d) % 20) == 10) d++;
                #d btn_in = ~btn_in;
            end
            repeat (2 * S + 4) @(negedge clk);
        end

        // Random segments with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                RST = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                RST = 1'b0;
            end
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * S + 2));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
